// File: rtl/bubble_output_buffer.sv
// Bubble output buffer: captures the SPI loader's write stream into a 2048 x 2-bit RAM and
// replays it as odd/even bubble data on shift ticks. Option: BUBBLE_OUT_ACTIVE_LOW_EN inverts the data outputs.
module bubble_output_buffer #(
    parameter int PAGE_PAIRS = 512,
    parameter int BOOT_PAIRS = 1920,
    parameter int ADDR_W     = 11
) (
    input  logic              master_clock,
    input  logic              reset,
    input  logic              load_mode,
    input  logic [ADDR_W-1:0] bubble_buffer_write_address,
    input  logic [1:0]        bubble_buffer_write_data_input,
    input  logic              bubble_buffer_write_enable,
    input  logic              bubble_buffer_write_clock,
    input  logic              stream_start,
    input  logic              bubble_shift_tick,
    output logic              bubble_out_odd,
    output logic              bubble_out_even,
    output logic              buffer_ready,
    output logic              stream_busy,
    output logic              page_done,
    output logic              load_error
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] DUMMY_ADDR = '1;
    localparam logic [ADDR_W-1:0] PAGE_CNT   = ADDR_W'(PAGE_PAIRS);
    localparam logic [ADDR_W-1:0] BOOT_CNT   = ADDR_W'(BOOT_PAIRS);

`ifdef BUBBLE_OUT_ACTIVE_LOW_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_READY,
        S_STREAM
    } state_t;

    state_t            r_state;
    logic              r_en;
    logic              r_en_d;
    logic              r_strobe;
    logic              r_strobe_d;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [1:0]        r_wr_data;
    logic              r_mode;
    logic [ADDR_W-1:0] r_wr_count;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [1:0]        r_rd_data;
    logic [1:0]        r_mem [0:DEPTH-1];
    logic              r_out_odd;
    logic              r_out_even;
    logic              r_buffer_ready;
    logic              r_stream_busy;
    logic              r_page_done;
    logic              r_load_error;

    logic              w_en_fall;
    logic              w_en_rise;
    logic              w_strobe_rise;
    logic              w_wr;
    logic [ADDR_W-1:0] w_count_next;
    logic [ADDR_W-1:0] w_expected;
    logic              w_issue;
    logic              w_last;

    assign w_en_fall     = r_en_d & ~r_en;
    assign w_en_rise     = ~r_en_d & r_en;
    // A strobe edge coinciding with the enable rise still belongs to the load that is ending.
    assign w_strobe_rise = r_strobe & ~r_strobe_d & (~r_en | w_en_rise);
    assign w_wr          = w_strobe_rise & (r_wr_addr != DUMMY_ADDR);
    assign w_count_next  = (w_wr && r_wr_count != '1) ? r_wr_count + 1'b1 : r_wr_count;
    assign w_expected    = r_mode ? BOOT_CNT : PAGE_CNT;
    assign w_issue       = (r_state == S_STREAM) && bubble_shift_tick && (r_rd_ptr < w_expected);
    assign w_last        = (r_rd_ptr == w_expected - 1'b1);

    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_en       <= 1'b1;
            r_en_d     <= 1'b1;
            r_strobe   <= 1'b0;
            r_strobe_d <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_en       <= bubble_buffer_write_enable;
            r_en_d     <= r_en;
            r_strobe   <= bubble_buffer_write_clock;
            r_strobe_d <= r_strobe;
            r_wr_addr  <= bubble_buffer_write_address;
            r_wr_data  <= bubble_buffer_write_data_input;
        end
    end

    always_ff @(posedge master_clock) begin
        if (w_wr) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge master_clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_wr_count     <= '0;
            r_rd_ptr       <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_last      <= 1'b0;
            r_out_odd      <= OUT_INV;
            r_out_even     <= OUT_INV;
            r_buffer_ready <= 1'b0;
            r_stream_busy  <= 1'b0;
            r_page_done    <= 1'b0;
            r_load_error   <= 1'b0;
        end else begin
            r_page_done <= 1'b0;
            r_rd_valid  <= w_issue;
            r_rd_last   <= w_last;
            if (w_en_fall) begin
                r_wr_count <= w_wr ? ADDR_W'(1) : '0;
            end else begin
                r_wr_count <= w_count_next;
            end

            // A new load pre-empts everything, including a replay in flight.
            if (w_en_fall) begin
                r_state        <= S_LOADING;
                r_mode         <= load_mode;
                r_buffer_ready <= 1'b0;
                r_stream_busy  <= 1'b0;
                r_rd_valid     <= 1'b0;
                r_rd_ptr       <= '0;
                r_out_odd      <= OUT_INV;
                r_out_even     <= OUT_INV;
            end else begin
                case (r_state)
                    S_LOADING: begin
                        if (w_en_rise) begin
                            if (w_count_next == w_expected) begin
                                r_state        <= S_READY;
                                r_buffer_ready <= 1'b1;
                                r_load_error   <= 1'b0;
                            end else begin
                                r_state      <= S_IDLE;
                                r_load_error <= 1'b1;
                            end
                        end
                    end
                    S_READY: begin
                        if (stream_start) begin
                            r_state        <= S_STREAM;
                            r_rd_ptr       <= '0;
                            r_buffer_ready <= 1'b0;
                            r_stream_busy  <= 1'b1;
                        end
                    end
                    S_STREAM: begin
                        if (w_issue) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                        if (r_page_done) begin
                            r_state       <= S_IDLE;
                            r_stream_busy <= 1'b0;
                            r_out_odd     <= OUT_INV;
                            r_out_even    <= OUT_INV;
                        end else if (r_rd_valid) begin
                            r_out_odd   <= r_rd_data[1] ^ OUT_INV;
                            r_out_even  <= r_rd_data[0] ^ OUT_INV;
                            r_page_done <= r_rd_last;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bubble_out_odd  = r_out_odd;
    assign bubble_out_even = r_out_even;
    assign buffer_ready    = r_buffer_ready;
    assign stream_busy     = r_stream_busy;
    assign page_done       = r_page_done;
    assign load_error      = r_load_error;

endmodule

// File: tb/tb_bubble_output_buffer.sv
// Randomized scoreboard bench for bubble_output_buffer: a behavioural buffer model predicts each
// replayed pair and its arrival time; a negedge monitor pops and compares them against the DUT.
module tb_bubble_output_buffer;

    localparam int PAGE_PAIRS = 512;
    localparam int BOOT_PAIRS = 1920;

`ifdef BUBBLE_OUT_ACTIVE_LOW_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    logic        master_clock = 1'b0;
    logic        reset        = 1'b1;
    logic        loadMode     = 1'b0;
    logic [10:0] wrAddr       = '0;
    logic [1:0]  wrData       = '0;
    logic        wrEnable     = 1'b1;
    logic        wrStrobe     = 1'b0;
    logic        streamStart  = 1'b0;
    logic        shiftTick    = 1'b0;
    logic        outOdd;
    logic        outEven;
    logic        bufferReady;
    logic        streamBusy;
    logic        pageDone;
    logic        loadError;

    bubble_output_buffer #(
        .PAGE_PAIRS(PAGE_PAIRS),
        .BOOT_PAIRS(BOOT_PAIRS),
        .ADDR_W(11)
    ) dut (
        .master_clock(master_clock),
        .reset(reset),
        .load_mode(loadMode),
        .bubble_buffer_write_address(wrAddr),
        .bubble_buffer_write_data_input(wrData),
        .bubble_buffer_write_enable(wrEnable),
        .bubble_buffer_write_clock(wrStrobe),
        .stream_start(streamStart),
        .bubble_shift_tick(shiftTick),
        .bubble_out_odd(outOdd),
        .bubble_out_even(outEven),
        .buffer_ready(bufferReady),
        .stream_busy(streamBusy),
        .page_done(pageDone),
        .load_error(loadError)
    );

    always #5 master_clock = ~master_clock;

    typedef struct {
        longint     due;
        logic [1:0] pair;
        logic       last;
    } expEntry_t;

    expEntry_t  expQ[$];
    int         checkCount = 0;
    int         failCount  = 0;

    logic [1:0] memModel [2048];
    int         mCount     = 0;
    int         mTotal     = 0;
    int         mIssued    = 0;
    bit         mMode      = 1'b0;
    bit         mReady     = 1'b0;
    bit         mErr       = 1'b0;
    bit         mStreaming = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checkCount++;
        if (act !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: a pair is due two cycles after its tick; page_done must accompany only the last pair.
    always @(negedge master_clock) begin : monitor
        expEntry_t e;
        logic      expPd;
        expPd = 1'b0;
        while (expQ.size() > 0 && expQ[0].due < $time) begin
            e = expQ.pop_front();
            checkOutput("pairTiming", 32'($time), 32'(e.due));
        end
        if (expQ.size() > 0 && expQ[0].due == $time) begin
            e = expQ.pop_front();
            checkOutput("oddBit", outOdd, e.pair[1] ^ IDLE_LVL);
            checkOutput("evenBit", outEven, e.pair[0] ^ IDLE_LVL);
            expPd = e.last;
        end
        checkOutput("pageDone", pageDone, expPd);
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge master_clock);
    endtask

    task automatic beginLoad(input bit mode);
        loadMode   = mode;
        wrEnable   = 1'b0;
        mCount     = 0;
        mMode      = mode;
        mReady     = 1'b0;
        mStreaming = 1'b0;
        waitCycles(3);
    endtask

    task automatic writePair(input int addr, input logic [1:0] data);
        wrAddr   = 11'(addr);
        wrData   = data;
        wrStrobe = 1'b1;
        waitCycles(1);
        wrStrobe = 1'b0;
        waitCycles(1);
        if (addr != 'h7FF) begin
            memModel[addr] = data;
            if (mCount < 2047) mCount++;
        end
    endtask

    task automatic endLoad();
        int expCount;
        waitCycles(1);
        wrEnable = 1'b1;
        expCount = mMode ? BOOT_PAIRS : PAGE_PAIRS;
        if (mCount == expCount) begin
            mReady = 1'b1;
            mErr   = 1'b0;
            mTotal = expCount;
        end else begin
            mReady = 1'b0;
            mErr   = 1'b1;
        end
        waitCycles(3);
        checkOutput("bufferReady", bufferReady, mReady);
        checkOutput("loadError", loadError, mErr);
    endtask

    task automatic startStream();
        streamStart = 1'b1;
        if (mReady) begin
            mStreaming = 1'b1;
            mIssued    = 0;
            mReady     = 1'b0;
        end
        waitCycles(1);
        streamStart = 1'b0;
        checkOutput("streamBusy", streamBusy, mStreaming);
        checkOutput("readyAfterStart", bufferReady, mReady);
    endtask

    task automatic applyStimulus(input int nTicks, input int maxGap, input bit randomGap);
        int gap;
        for (int i = 0; i < nTicks; i++) begin
            shiftTick = 1'b1;
            if (mStreaming && mIssued < mTotal) begin
                expQ.push_back('{due: longint'($time) + 20, pair: memModel[mIssued],
                                 last: (mIssued == mTotal - 1)});
                mIssued++;
                if (mIssued == mTotal) mStreaming = 1'b0;
            end
            waitCycles(1);
            gap = randomGap ? int'($urandom_range(maxGap, 0)) : maxGap;
            if (gap > 0) begin
                shiftTick = 1'b0;
                waitCycles(gap);
            end
        end
        shiftTick = 1'b0;
    endtask

    task automatic idleCheck(input string tag);
        checkOutput({tag, "Odd"}, outOdd, IDLE_LVL);
        checkOutput({tag, "Even"}, outEven, IDLE_LVL);
        checkOutput({tag, "Busy"}, streamBusy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(1);
        idleCheck("reset");
        checkOutput("resetReady", bufferReady, 1'b0);
        checkOutput("resetError", loadError, 1'b0);

        $display("[TB] page load and 4-cycle-spaced replay");
        beginLoad(1'b0);
        writePair('h7FF, 2'b11);
        for (int a = 0; a < PAGE_PAIRS; a++) writePair(a, 2'(a));
        endLoad();
        startStream();
        applyStimulus(PAGE_PAIRS + 4, 3, 1'b0);
        waitCycles(4);
        idleCheck("pageEnd");

        $display("[TB] short load then ignored stream_start");
        beginLoad(1'b0);
        for (int a = 0; a < 300; a++) writePair(a, 2'($urandom));
        endLoad();
        startStream();
        waitCycles(2);
        checkOutput("busyIgnored", streamBusy, 1'b0);

        $display("[TB] bootloader load and back-to-back replay");
        beginLoad(1'b1);
        writePair('h7FF, 2'($urandom));
        for (int a = 0; a < BOOT_PAIRS; a++) writePair(a, 2'($urandom));
        endLoad();
        startStream();
        applyStimulus(BOOT_PAIRS, 0, 1'b0);
        waitCycles(4);
        idleCheck("bootEnd");

        $display("[TB] abort mid-stream and reload");
        beginLoad(1'b0);
        for (int a = 0; a < PAGE_PAIRS; a++) writePair(a, 2'($urandom));
        endLoad();
        startStream();
        applyStimulus(100, 2, 1'b1);
        waitCycles(3);
        beginLoad(1'b0);
        idleCheck("abort");
        checkOutput("abortReady", bufferReady, 1'b0);
        for (int a = 0; a < PAGE_PAIRS; a++) writePair(a, (a < 4) ? 2'b10 : 2'($urandom));
        endLoad();

        $display("[TB] reset during replay");
        startStream();
        applyStimulus(20, 1, 1'b1);
        waitCycles(3);
        reset = 1'b1;
        waitCycles(1);
        reset      = 1'b0;
        mStreaming = 1'b0;
        mReady     = 1'b0;
        mErr       = 1'b0;
        idleCheck("midReset");
        checkOutput("midResetReady", bufferReady, 1'b0);
        checkOutput("midResetError", loadError, 1'b0);
        waitCycles(2);
        checkOutput("queueDrained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0t expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
